// File: rtl/pipelined_mac_if.sv
// Operand/result bundle for pipelined_mac; the master drives operands, the slave returns results.
interface pipelined_mac_if #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ACC_W  = 33
);
  logic              valid_i;
  logic              acc_clr_i;
  logic              last_i;
  logic [DATA_W-1:0] data_a_i;
  logic [DATA_W-1:0] data_b_i;
  logic [ACC_W-1:0]  result_o;
  logic              valid_o;
  logic              last_o;
  logic              ovf_o;

  modport master (
    output valid_i, acc_clr_i, last_i, data_a_i, data_b_i,
    input  result_o, valid_o, last_o, ovf_o
  );

  modport slave (
    input  valid_i, acc_clr_i, last_i, data_a_i, data_b_i,
    output result_o, valid_o, last_o, ovf_o
  );
endinterface

// File: rtl/pipelined_mac.sv
// Pipelined multiply-accumulate: product register, accumulator, then LATENCY-2 delay stages.
// Define MAC_SAT_EN for saturating accumulation with a sticky per-frame overflow flag.
module pipelined_mac #(
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned ACC_W   = 33,
  parameter int unsigned LATENCY = 3,
  parameter bit          SIGNED  = 1'b0
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            clk_en_i,
  pipelined_mac_if.slave  bus
);

  localparam int unsigned Msb = ACC_W - 1;

  logic [2*DATA_W-1:0] w_a_ext, w_b_ext, w_prod;
  logic [ACC_W-1:0]    w_prod_ext;

  // Extending operands to the full product width makes the truncated product correct
  // for both signed and unsigned operands.
  always_comb begin
    w_a_ext                = (SIGNED && bus.data_a_i[DATA_W-1]) ? '1 : '0;
    w_a_ext[DATA_W-1:0]    = bus.data_a_i;
    w_b_ext                = (SIGNED && bus.data_b_i[DATA_W-1]) ? '1 : '0;
    w_b_ext[DATA_W-1:0]    = bus.data_b_i;
    w_prod                 = w_a_ext * w_b_ext;
    w_prod_ext             = (SIGNED && w_prod[2*DATA_W-1]) ? '1 : '0;
    w_prod_ext[2*DATA_W-1:0] = w_prod;
  end

  logic             r_s1_valid, r_s1_clr, r_s1_last;
  logic [ACC_W-1:0] r_s1_prod;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_s1_valid <= 1'b0;
      r_s1_clr   <= 1'b0;
      r_s1_last  <= 1'b0;
      r_s1_prod  <= '0;
    end else if (clk_en_i) begin
      r_s1_valid <= bus.valid_i;
      r_s1_clr   <= bus.valid_i & bus.acc_clr_i;
      r_s1_last  <= bus.valid_i & bus.last_i;
      r_s1_prod  <= w_prod_ext;
    end
  end

  logic             r_s2_valid, r_s2_last, r_ovf;
  logic [ACC_W-1:0] r_acc;
  logic [ACC_W-1:0] w_base, w_acc_d;
  logic             w_ovf_d;

`ifdef MAC_SAT_EN
  logic [ACC_W:0] w_sum_ext;
  logic           w_ovf_add;

  always_comb begin
    w_base    = r_s1_clr ? '0 : r_acc;
    w_sum_ext = {1'b0, w_base} + {1'b0, r_s1_prod};
    if (SIGNED) begin
      w_ovf_add = (w_base[Msb] == r_s1_prod[Msb]) && (w_sum_ext[Msb] != w_base[Msb]);
    end else begin
      w_ovf_add = w_sum_ext[ACC_W];
    end
    w_acc_d = w_sum_ext[ACC_W-1:0];
    // Signed overflow direction follows the product sign, since both addends share it.
    if (w_ovf_add) begin
      if (!SIGNED)              w_acc_d = '1;
      else if (r_s1_prod[Msb])  w_acc_d = {1'b1, {(ACC_W-1){1'b0}}};
      else                      w_acc_d = {1'b0, {(ACC_W-1){1'b1}}};
    end
    w_ovf_d = (r_s1_clr ? 1'b0 : r_ovf) | w_ovf_add;
  end
`else
  always_comb begin
    w_base  = r_s1_clr ? '0 : r_acc;
    w_acc_d = w_base + r_s1_prod;
    w_ovf_d = 1'b0;
  end
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_acc      <= '0;
      r_ovf      <= 1'b0;
      r_s2_valid <= 1'b0;
      r_s2_last  <= 1'b0;
    end else if (clk_en_i) begin
      r_s2_valid <= r_s1_valid;
      r_s2_last  <= r_s1_last;
      if (r_s1_valid) begin
        r_acc <= w_acc_d;
        r_ovf <= w_ovf_d;
      end
    end
  end

  // Bubbles carry the held accumulator, so result_o keeps the last sum across them.
  if (LATENCY > 2) begin : g_dly
    localparam int unsigned N = LATENCY - 2;
    logic [ACC_W-1:0] r_res [N];
    logic [N-1:0]     r_vld, r_lst, r_ovf_dly;

    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        for (int i = 0; i < N; i++) r_res[i] <= '0;
        r_vld     <= '0;
        r_lst     <= '0;
        r_ovf_dly <= '0;
      end else if (clk_en_i) begin
        r_res[0]     <= r_acc;
        r_vld[0]     <= r_s2_valid;
        r_lst[0]     <= r_s2_last;
        r_ovf_dly[0] <= r_ovf;
        for (int i = 1; i < N; i++) begin
          r_res[i]     <= r_res[i-1];
          r_vld[i]     <= r_vld[i-1];
          r_lst[i]     <= r_lst[i-1];
          r_ovf_dly[i] <= r_ovf_dly[i-1];
        end
      end
    end

    assign bus.result_o = r_res[N-1];
    assign bus.valid_o  = r_vld[N-1];
    assign bus.last_o   = r_lst[N-1];
    assign bus.ovf_o    = r_ovf_dly[N-1];
  end else begin : g_nodly
    assign bus.result_o = r_acc;
    assign bus.valid_o  = r_s2_valid;
    assign bus.last_o   = r_s2_last;
    assign bus.ovf_o    = r_ovf;
  end

endmodule

// File: tb/tb_pipelined_mac.sv
// Self-checking bench: unsigned and signed pipelined_mac instances against an arithmetic model.
module tb_pipelined_mac;
  localparam int unsigned DW  = 16;
  localparam int unsigned AW  = 33;
  localparam int unsigned LAT = 3;
  localparam longint      MASK = (longint'(1) << AW) - 1;

  typedef struct {
    logic          v;
    logic          l;
    logic [AW-1:0] r;
    logic          o;
  } exp_t;

  logic clk = 1'b0;
  logic rst, en;
  always #5 clk = ~clk;

  pipelined_mac_if #(.DATA_W(DW), .ACC_W(AW)) bus_u ();
  pipelined_mac_if #(.DATA_W(DW), .ACC_W(AW)) bus_s ();

  pipelined_mac #(.DATA_W(DW), .ACC_W(AW), .LATENCY(LAT), .SIGNED(1'b0)) u_dut_u (
    .clk_i(clk), .rst_i(rst), .clk_en_i(en), .bus(bus_u)
  );
  pipelined_mac #(.DATA_W(DW), .ACC_W(AW), .LATENCY(LAT), .SIGNED(1'b1)) u_dut_s (
    .clk_i(clk), .rst_i(rst), .clk_en_i(en), .bus(bus_s)
  );

  int   n_vec = 0;
  int   n_err = 0;
  longint acc_m [2];
  logic   ovf_m [2];
  exp_t   q_u[$], q_s[$];
  exp_t   cur_u, cur_s;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
    end
  endtask

  // Mathematical sum, then clamp or wrap into the accumulator's representable range.
  function automatic exp_t model_item(input int m, input logic v, input logic c, input logic l,
                                      input logic [DW-1:0] a, input logic [DW-1:0] b);
    exp_t   e;
    longint p, s, lo, hi;
    logic   over;
    if (v) begin
      if (m == 1) begin
        p  = longint'($signed(a)) * longint'($signed(b));
        lo = -(longint'(1) << (AW - 1));
        hi = (longint'(1) << (AW - 1)) - 1;
      end else begin
        p  = longint'(a) * longint'(b);
        lo = 0;
        hi = MASK;
      end
      s    = (c ? longint'(0) : acc_m[m]) + p;
      over = (s > hi) || (s < lo);
`ifdef MAC_SAT_EN
      if (over) s = (s > hi) ? hi : lo;
      ovf_m[m] = (c ? 1'b0 : ovf_m[m]) | over;
`else
      if (over) begin
        s = s & MASK;
        if (s > hi) s = s - (longint'(1) << AW);
      end
`endif
      acc_m[m] = s;
    end
    e.v = v;
    e.l = v & l;
    e.r = acc_m[m][AW-1:0];
    e.o = ovf_m[m];
    return e;
  endfunction

  task automatic reset_model();
    exp_t z;
    z.v = 1'b0; z.l = 1'b0; z.r = '0; z.o = 1'b0;
    for (int m = 0; m < 2; m++) begin
      acc_m[m] = 0;
      ovf_m[m] = 1'b0;
    end
    q_u.delete();
    q_s.delete();
    for (int i = 0; i < LAT - 1; i++) begin
      q_u.push_back(z);
      q_s.push_back(z);
    end
    cur_u = z;
    cur_s = z;
  endtask

  task automatic check_outputs();
    chk("res_u", 64'(bus_u.result_o), 64'(cur_u.r));
    chk("vld_u", 64'(bus_u.valid_o),  64'(cur_u.v));
    chk("lst_u", 64'(bus_u.last_o),   64'(cur_u.l));
    if (cur_u.v) chk("ovf_u", 64'(bus_u.ovf_o), 64'(cur_u.o));
    chk("res_s", 64'(bus_s.result_o), 64'(cur_s.r));
    chk("vld_s", 64'(bus_s.valid_o),  64'(cur_s.v));
    chk("lst_s", 64'(bus_s.last_o),   64'(cur_s.l));
    if (cur_s.v) chk("ovf_s", 64'(bus_s.ovf_o), 64'(cur_s.o));
  endtask

  task automatic step(input logic r, input logic e, input logic v, input logic c, input logic l,
                      input logic [DW-1:0] a, input logic [DW-1:0] b);
    rst = r;
    en  = e;
    bus_u.valid_i = v; bus_u.acc_clr_i = c; bus_u.last_i = l;
    bus_u.data_a_i = a; bus_u.data_b_i = b;
    bus_s.valid_i = v; bus_s.acc_clr_i = c; bus_s.last_i = l;
    bus_s.data_a_i = a; bus_s.data_b_i = b;
    @(posedge clk);
    #1;
    if (r) begin
      reset_model();
    end else if (e) begin
      q_u.push_back(model_item(0, v, c, l, a, b));
      q_s.push_back(model_item(1, v, c, l, a, b));
      cur_u = q_u.pop_front();
      cur_s = q_s.pop_front();
    end
    check_outputs();
  endtask

  task automatic idle();
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, '0, '0);
  endtask

  initial begin
    reset_model();
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, '0, '0);
    step(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 16'h1234, 16'h5678);
    chk("rst_res", 64'(bus_u.result_o), 64'd0);
    chk("rst_vld", 64'(bus_u.valid_o), 64'd0);

    // Two-item frame: 12 then 42, first result two edges after acceptance.
    step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 16'd3, 16'd4);
    chk("lat_v0", 64'(bus_u.valid_o), 64'd0);
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 16'd5, 16'd6);
    chk("lat_v1", 64'(bus_u.valid_o), 64'd0);
    idle();
    chk("f1_12", 64'(bus_u.result_o), 64'd12);
    chk("f1_l0", 64'(bus_u.last_o), 64'd0);
    idle();
    chk("f1_42", 64'(bus_u.result_o), 64'd42);
    chk("f1_l1", 64'(bus_u.last_o), 64'd1);

    // Bubbles between items; stray clr/last on an idle cycle must be ignored.
    step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 16'd1, 16'd1);
    step(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 16'd9, 16'd9);
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 16'd2, 16'd2);
    chk("bub_1", 64'(bus_u.result_o), 64'd1);
    idle();
    chk("bub_v0", 64'(bus_u.valid_o), 64'd0);
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 16'd3, 16'd3);
    chk("bub_5", 64'(bus_u.result_o), 64'd5);
    idle();
    idle();
    chk("bub_14", 64'(bus_u.result_o), 64'd14);

    // Enable dropped for two cycles mid-stream.
    step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 16'd1, 16'd2);
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 16'd3, 16'd4);
    step(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 16'd100, 16'd100);
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'd100, 16'd100);
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 16'd5, 16'd6);
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 16'd7, 16'd8);
    idle();
    idle();
    chk("frz_100", 64'(bus_u.result_o), 64'd100);

    // Unsigned overflow on the third max product.
    step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 16'hFFFF, 16'hFFFF);
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 16'hFFFF, 16'hFFFF);
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 16'hFFFF, 16'hFFFF);
    idle();
    chk("ovf_i2", 64'(bus_u.result_o), 64'h1_FFFC_0002);
    idle();
`ifdef MAC_SAT_EN
    chk("ovf_i3", 64'(bus_u.result_o), 64'h1_FFFF_FFFF);
    chk("ovf_f", 64'(bus_u.ovf_o), 64'd1);
`else
    chk("ovf_i3", 64'(bus_u.result_o), 64'h0_FFFA_0003);
    chk("ovf_f", 64'(bus_u.ovf_o), 64'd0);
`endif

    // Signed frame: -21 then -29 on the signed instance.
    step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 16'hFFFD, 16'd7);
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 16'd2, 16'hFFFC);
    idle();
    chk("sgn_m21", 64'(bus_s.result_o), 64'h1_FFFF_FFEB);
    idle();
    chk("sgn_m29", 64'(bus_s.result_o), 64'h1_FFFF_FFE3);
    chk("sgn_l1", 64'(bus_s.last_o), 64'd1);

    // Reset with two items in flight, then a one-item frame.
    step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 16'd1, 16'd1);
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 16'd2, 16'd2);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, '0, '0);
    step(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 16'd2, 16'd3);
    chk("rmf_v0", 64'(bus_u.valid_o), 64'd0);
    idle();
    chk("rmf_v1", 64'(bus_u.valid_o), 64'd0);
    idle();
    chk("rmf_6", 64'(bus_u.result_o), 64'd6);
    chk("rmf_l", 64'(bus_u.last_o), 64'd1);

    for (int i = 0; i < 600; i++) begin
      logic          r, e, v, c, l;
      logic [DW-1:0] a, b;
      r = ($urandom_range(0, 199) == 0);
      e = ($urandom_range(0, 99) < 85);
      v = ($urandom_range(0, 99) < 75);
      c = ($urandom_range(0, 99) < 12);
      l = ($urandom_range(0, 99) < 20);
      case ($urandom_range(0, 3))
        0:       a = 16'hFFFF;
        1:       a = 16'h8000;
        default: a = DW'($urandom);
      endcase
      case ($urandom_range(0, 3))
        0:       b = 16'hFFFF;
        1:       b = 16'h8000;
        default: b = DW'($urandom);
      endcase
      step(r, e, v, c, l, a, b);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/pipelined_mac.md
PIPELINED_MAC -- requirements
Module: pipelined_mac

Interface
REQ-001 Parameter DATA_W, default 16: operand width in bits, range 2..32.
REQ-002 Parameter ACC_W, default 33: accumulator/result width; SHALL be >= 2*DATA_W.
REQ-003 Parameter LATENCY, default 3: input-to-output latency in enabled cycles; range 2..8.
REQ-004 Parameter SIGNED, default 0: 0 means operands unsigned; 1 means two's complement.
REQ-005 clk_i  in  1  single clock; all state updates on its rising edge.
REQ-006 rst_i  in  1  reset; synchronous, active-high.
REQ-007 clk_en_i  in  1  pipeline enable; 0 freezes all state.
REQ-008 valid_i  in  1  operand pair on data_a_i/data_b_i is valid this cycle.
REQ-009 acc_clr_i  in  1  with valid_i, this pair starts a new frame (accumulate from 0).
REQ-010 last_i  in  1  with valid_i, this pair ends the frame.
REQ-011 data_a_i  in  DATA_W  multiplicand.
REQ-012 data_b_i  in  DATA_W  multiplier.
REQ-013 result_o  out  ACC_W  running accumulated sum for the matching input.
REQ-014 valid_o  out  1  result_o is valid.
REQ-015 last_o  out  1  result_o is the final sum of a frame.
REQ-016 ovf_o  out  1  sticky overflow flag for the current frame.

Function
REQ-017 Stage 1 SHALL register the full 2*DATA_W product, sign- or zero-extended to ACC_W according to SIGNED.
REQ-018 Stage 2 SHALL set acc to (acc_clr ? 0 : acc) + product when the stage-1 item is valid; acc SHALL hold when it is not.
REQ-019 LATENCY-2 pure delay stages SHALL follow stage 2; valid, last and ovf SHALL travel in lockstep with the data.
REQ-020 With clk_en_i=1 throughout, an item accepted at edge N SHALL appear on the outputs after edge N+LATENCY-1.
REQ-021 The block SHALL accept one item per enabled cycle, back to back, with no stalls.
REQ-022 Every stage SHALL hold its contents while clk_en_i=0; the outputs SHALL stay stable during that time.
REQ-023 Cycles with valid_i=0 SHALL produce bubbles: valid_o=0 in the matching output cycle, and result_o SHALL keep its last value.
REQ-024 acc_clr_i and last_i SHALL be ignored when valid_i=0.
REQ-025 acc_clr_i=1 together with last_i=1 SHALL form a one-item frame: result = product, last_o=1.
REQ-026 Without acc_clr_i, accumulation SHALL continue across frame boundaries.
REQ-027 Overflow (see REQ-033/034) SHALL be detected on the stage-2 addition only.

Reset
REQ-028 rst_i=1 at an edge SHALL zero acc, all pipeline data and all valid/last/ovf bits.
REQ-029 rst_i SHALL take priority over clk_en_i.
REQ-030 After reset: result_o=0, valid_o=0, last_o=0, ovf_o=0.
REQ-031 Reset in mid-frame SHALL discard all in-flight items; no valid_o SHALL follow for them.
REQ-032 An item presented in the cycle rst_i deasserts SHALL be accepted as normal.

Configuration
REQ-033 With macro MAC_SAT_EN defined, an overflowing add SHALL clamp acc (unsigned: to 2^ACC_W-1; signed: to max or min by direction) and set ovf, which SHALL stay set until the next acc_clr or reset.
REQ-034 Without MAC_SAT_EN, the add SHALL wrap modulo 2^ACC_W and ovf_o SHALL be constant 0.

Verification
REQ-035 Defaults; reset, then (3,4,clr), (5,6,last) back to back -> result_o 12 then 42; last_o=1 on 42 only; first valid_o 2 cycles after first acceptance.
REQ-036 (1,1,clr), idle, (2,2), idle, (3,3,last) -> valid_o pattern 1,0,1,0,1; results 1, 5, 14.
REQ-037 clk_en_i=0 for 2 cycles mid-stream of 4 items -> outputs frozen 2 cycles; sequence otherwise identical, delayed by 2.
REQ-038 Unsigned; 3x (0xFFFF,0xFFFF) from clr -> item 2 gives 0x1FFFC0002; item 3 with MAC_SAT_EN gives 0x1FFFFFFFF, ovf_o=1; without it gives 0x0FFFA0003, ovf_o=0.
REQ-039 SIGNED=1: (-3,7,clr), (2,-4,last) -> result_o -21 then -29, sign-extended to 33 bits.
REQ-040 rst_i pulse while 2 items are in flight -> no valid_o for them; next frame (2,3,clr+last) -> result_o 6.
